// File: rtl/host_mem_pkg.sv
// Shared types for the host memory responder model.
// Line/tag/stamp widths, FSM states and delay-queue entry layouts.
package host_mem_pkg;

    localparam int ADDR_BITS  = 6;
    localparam int DATA_BITS  = 512;
    localparam int MDATA_BITS = 16;
    localparam int STAMP_BITS = 16;
    localparam int LINES      = 2 ** ADDR_BITS;

    typedef logic [ADDR_BITS-1:0]  t_line_addr;
    typedef logic [DATA_BITS-1:0]  t_line_data;
    typedef logic [MDATA_BITS-1:0] t_mdata;
    typedef logic [STAMP_BITS-1:0] t_stamp;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } t_hm_state;

    typedef struct packed {
        t_line_addr addr;
        t_line_data data;
        t_mdata     mdata;
        t_stamp     due;
    } t_rd_entry;

    typedef struct packed {
        t_mdata mdata;
        t_stamp due;
    } t_wr_entry;

    // Due stamp for an entry accepted while the counter reads `now`.
    function automatic t_stamp due_stamp(input t_stamp now, input int lat);
        return now + t_stamp'(lat);
    endfunction

endpackage

// File: rtl/resp_delay_fifo.sv
// In-order delay queue: an entry is issued when its due stamp matches i_now.
// A slot stays occupied through the cycle its response is on the outputs.
module resp_delay_fifo
    import host_mem_pkg::*;
#(
    parameter type T     = logic,
    parameter int  DEPTH = 8
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_push,
    input  T       i_push_data,
    input  t_stamp i_push_due,
    input  t_stamp i_head_due,
    input  t_stamp i_now,
    output T       o_head,
    output logic   o_pop_valid,
    output T       o_pop_data,
    output logic   o_push_ok,
    output logic   o_full,
    output logic   o_almfull,
    output logic   o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T               r_mem [DEPTH];
    logic [CW-1:0]  r_wr;
    logic [CW-1:0]  r_rd;
    logic [CW-1:0]  r_cnt;
    logic           r_rel;

    logic w_empty;
    logic w_space;
    logic w_head_due;
    logic w_bypass;
    logic w_store;

    assign w_empty     = (r_wr == r_rd);
    assign w_space     = (r_cnt != CW'(DEPTH)) || r_rel;
    assign o_push_ok   = i_push && w_space;
    assign o_overflow  = i_push && !w_space;
    assign o_head      = r_mem[r_rd[AW-1:0]];
    assign w_head_due  = !w_empty && (i_head_due == i_now);
    assign w_bypass    = w_empty && o_push_ok && (i_push_due == i_now);
    assign w_store     = o_push_ok && !w_bypass;
    assign o_pop_valid = w_head_due || w_bypass;
    assign o_pop_data  = w_empty ? i_push_data : o_head;
    assign o_full      = (r_cnt == CW'(DEPTH));
    assign o_almfull   = (r_cnt >= CW'(DEPTH - 2));

    // Pointers advance on store/issue; occupancy drops the cycle after issue.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_rel <= 1'b0;
        end else begin
            r_rel <= o_pop_valid;
            r_cnt <= r_cnt + CW'(o_push_ok) - CW'(r_rel);
            if (w_store)
                r_wr <= r_wr + CW'(1);
            if (w_head_due)
                r_rd <= r_rd + CW'(1);
        end
    end

    // Entry storage needs no reset; pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_store)
            r_mem[r_wr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/host_mem_responder.sv
// Host-side CCI memory model: clears its line memory, then serves line
// reads and writes with fixed-latency, in-order responses.
module host_mem_responder
    import host_mem_pkg::*;
#(
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2,
    parameter int Q_DEPTH    = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rd_req_valid,
    input  logic [ADDR_BITS-1:0]  i_rd_req_addr,
    input  logic [MDATA_BITS-1:0] i_rd_req_mdata,
    output logic                  o_rd_almfull,
    output logic                  o_rd_rsp_valid,
    output logic [DATA_BITS-1:0]  o_rd_rsp_data,
    output logic [MDATA_BITS-1:0] o_rd_rsp_mdata,
    input  logic                  i_wr_req_valid,
    input  logic [ADDR_BITS-1:0]  i_wr_req_addr,
    input  logic [DATA_BITS-1:0]  i_wr_req_data,
    input  logic [MDATA_BITS-1:0] i_wr_req_mdata,
    output logic                  o_wr_almfull,
    output logic                  o_wr_rsp_valid,
    output logic [MDATA_BITS-1:0] o_wr_rsp_mdata,
    output logic                  o_init_done,
    output logic [2:0]            o_err_flags
);

    t_line_data r_mem [LINES];
    t_hm_state  r_state;
    t_line_addr r_clr_ptr;
    t_stamp     r_now;
    logic       r_init_done;
    logic       r_rd_almfull;
    logic       r_wr_almfull;
    logic [2:0] r_err;

    logic       w_run;
    logic       w_init_next;
    t_stamp     w_now_next;
    t_rd_entry  w_rd_in, w_rd_head, w_rd_pop;
    t_wr_entry  w_wr_in, w_wr_head, w_wr_pop;
    logic       w_rd_pop_v, w_rd_push_ok, w_rd_full, w_rd_alm, w_rd_ovf;
    logic       w_wr_pop_v, w_wr_push_ok, w_wr_full, w_wr_alm, w_wr_ovf;
    logic       w_unused;

    assign w_run       = (r_state == ST_RUN);
    assign w_init_next = (r_state == ST_INIT) && (r_clr_ptr != '1);
    assign w_now_next  = r_now + t_stamp'(1);

    // Read data is snapshotted before any same-edge write lands.
    always_comb begin
        w_rd_in       = '0;
        w_rd_in.addr  = i_rd_req_addr;
        w_rd_in.data  = r_mem[i_rd_req_addr];
        w_rd_in.mdata = i_rd_req_mdata;
        w_rd_in.due   = due_stamp(r_now, RD_LATENCY);
        w_wr_in       = '0;
        w_wr_in.mdata = i_wr_req_mdata;
        w_wr_in.due   = due_stamp(r_now, WR_LATENCY);
    end

    resp_delay_fifo #(.T(t_rd_entry), .DEPTH(Q_DEPTH)) u_rd_q (
        .i_clk       (i_clk),
        .i_rst       (i_reset),
        .i_push      (i_rd_req_valid && w_run),
        .i_push_data (w_rd_in),
        .i_push_due  (w_rd_in.due),
        .i_head_due  (w_rd_head.due),
        .i_now       (w_now_next),
        .o_head      (w_rd_head),
        .o_pop_valid (w_rd_pop_v),
        .o_pop_data  (w_rd_pop),
        .o_push_ok   (w_rd_push_ok),
        .o_full      (w_rd_full),
        .o_almfull   (w_rd_alm),
        .o_overflow  (w_rd_ovf)
    );

    resp_delay_fifo #(.T(t_wr_entry), .DEPTH(Q_DEPTH)) u_wr_q (
        .i_clk       (i_clk),
        .i_rst       (i_reset),
        .i_push      (i_wr_req_valid && w_run),
        .i_push_data (w_wr_in),
        .i_push_due  (w_wr_in.due),
        .i_head_due  (w_wr_head.due),
        .i_now       (w_now_next),
        .o_head      (w_wr_head),
        .o_pop_valid (w_wr_pop_v),
        .o_pop_data  (w_wr_pop),
        .o_push_ok   (w_wr_push_ok),
        .o_full      (w_wr_full),
        .o_almfull   (w_wr_alm),
        .o_overflow  (w_wr_ovf)
    );

    assign w_unused = ^{w_rd_head.addr, w_rd_head.data, w_rd_head.mdata,
                        w_rd_pop.addr, w_rd_pop.due, w_rd_full,
                        w_wr_head.mdata, w_wr_pop.due, w_rd_push_ok,
                        w_wr_full};

    // Line memory: cleared line by line in INIT, accepted writes in RUN.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT)
            r_mem[r_clr_ptr] <= '0;
        else if (w_wr_push_ok)
            r_mem[i_wr_req_addr] <= i_wr_req_data;
    end

    // Init FSM: sweep the clear pointer once, then stay in RUN.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_INIT;
            r_clr_ptr   <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_ptr <= r_clr_ptr + t_line_addr'(1);
                    if (r_clr_ptr == '1) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Free-running stamp counter, advisory almfull and sticky errors.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_now        <= '0;
            r_rd_almfull <= 1'b0;
            r_wr_almfull <= 1'b0;
            r_err        <= '0;
        end else begin
            r_now        <= w_now_next;
            r_rd_almfull <= w_init_next || w_rd_alm;
            r_wr_almfull <= w_init_next || w_wr_alm;
            r_err[0]     <= r_err[0] | w_rd_ovf;
            r_err[1]     <= r_err[1] | w_wr_ovf;
            r_err[2]     <= r_err[2] |
                            (!w_run && (i_rd_req_valid || i_wr_req_valid));
        end
    end

    // Registered response strobes; payload holds when idle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rd_rsp_valid <= 1'b0;
            o_rd_rsp_data  <= '0;
            o_rd_rsp_mdata <= '0;
            o_wr_rsp_valid <= 1'b0;
            o_wr_rsp_mdata <= '0;
        end else begin
            o_rd_rsp_valid <= w_rd_pop_v;
            o_wr_rsp_valid <= w_wr_pop_v;
            if (w_rd_pop_v) begin
                o_rd_rsp_data  <= w_rd_pop.data;
                o_rd_rsp_mdata <= w_rd_pop.mdata;
            end
            if (w_wr_pop_v)
                o_wr_rsp_mdata <= w_wr_pop.mdata;
        end
    end

    assign o_rd_almfull = r_rd_almfull;
    assign o_wr_almfull = r_wr_almfull;
    assign o_init_done  = r_init_done;
    assign o_err_flags  = r_err;

endmodule

// File: tb/tb_host_mem_responder.sv
// Scoreboard bench for host_mem_responder: default instance plus an
// instance with RD_LATENCY=12 to exercise read-queue overflow.
module tb_host_mem_responder;

    typedef struct {
        logic [15:0]  mdata;
        logic [511:0] data;
        int           at;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    logic         rd_v = 1'b0;
    logic [5:0]   rd_a = '0;
    logic [15:0]  rd_m = '0;
    logic         wr_v = 1'b0;
    logic [5:0]   wr_a = '0;
    logic [511:0] wr_d = '0;
    logic [15:0]  wr_m = '0;
    logic         rd_alm, rd_rv, wr_alm, wr_rv, init_done;
    logic [511:0] rd_rd;
    logic [15:0]  rd_rm, wr_rm;
    logic [2:0]   err;

    logic         v_rd_v = 1'b0;
    logic [15:0]  v_rd_m = '0;
    logic         v_rd_alm, v_rd_rv, v_wr_alm, v_wr_rv, v_init;
    logic [511:0] v_rd_rd;
    logic [15:0]  v_rd_rm, v_wr_rm;
    logic [2:0]   v_err;

    exp_t         rd_q[$];
    exp_t         wr_q[$];
    exp_t         ovf_q[$];
    exp_t         me;
    logic [511:0] mem_m [64];
    int           n_ovf = 0;
    int           n;

    host_mem_responder u_dut (
        .i_clk(clk), .i_reset(reset),
        .i_rd_req_valid(rd_v), .i_rd_req_addr(rd_a), .i_rd_req_mdata(rd_m),
        .o_rd_almfull(rd_alm), .o_rd_rsp_valid(rd_rv),
        .o_rd_rsp_data(rd_rd), .o_rd_rsp_mdata(rd_rm),
        .i_wr_req_valid(wr_v), .i_wr_req_addr(wr_a),
        .i_wr_req_data(wr_d), .i_wr_req_mdata(wr_m),
        .o_wr_almfull(wr_alm), .o_wr_rsp_valid(wr_rv),
        .o_wr_rsp_mdata(wr_rm), .o_init_done(init_done),
        .o_err_flags(err)
    );

    host_mem_responder #(.RD_LATENCY(12)) u_ovf (
        .i_clk(clk), .i_reset(reset),
        .i_rd_req_valid(v_rd_v), .i_rd_req_addr(6'd2),
        .i_rd_req_mdata(v_rd_m),
        .o_rd_almfull(v_rd_alm), .o_rd_rsp_valid(v_rd_rv),
        .o_rd_rsp_data(v_rd_rd), .o_rd_rsp_mdata(v_rd_rm),
        .i_wr_req_valid(1'b0), .i_wr_req_addr(6'd0),
        .i_wr_req_data(512'd0), .i_wr_req_mdata(16'd0),
        .o_wr_almfull(v_wr_alm), .o_wr_rsp_valid(v_wr_rv),
        .o_wr_rsp_mdata(v_wr_rm), .o_init_done(v_init),
        .o_err_flags(v_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic io(input bit rv, input logic [5:0] ra,
                      input logic [15:0] rm, input bit wv,
                      input logic [5:0] wa, input logic [511:0] wd,
                      input logic [15:0] wm);
        rd_v = rv; rd_a = ra; rd_m = rm;
        wr_v = wv; wr_a = wa; wr_d = wd; wr_m = wm;
        if (rv)
            rd_q.push_back('{mdata: rm, data: mem_m[ra], at: cyc + 4});
        if (wv) begin
            mem_m[wa] = wd;
            wr_q.push_back('{mdata: wm, data: '0, at: cyc + 2});
        end
        @(posedge clk); #1;
        rd_v = 1'b0;
        wr_v = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++)
            mem_m[i] = '0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_rv) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", 1, 0);
                end else begin
                    me = rd_q.pop_front();
                    chk("rd_mdata", rd_rm, me.mdata);
                    chk("rd_data", rd_rd, me.data);
                    chk("rd_cycle", cyc, me.at);
                end
            end
            if (wr_rv) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    me = wr_q.pop_front();
                    chk("wr_mdata", wr_rm, me.mdata);
                    chk("wr_cycle", cyc, me.at);
                end
            end
            if (v_rd_rv) begin
                n_ovf++;
                if (ovf_q.size() == 0) begin
                    chk("ovf_unexpected", 1, 0);
                end else begin
                    me = ovf_q.pop_front();
                    chk("ovf_mdata", v_rd_rm, me.mdata);
                    chk("ovf_cycle", cyc, me.at);
                end
            end
        end
    end

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_rv, 0);
        chk("rst_wr_valid", wr_rv, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_err", err, 0);

        @(negedge clk) reset = 1'b0;
        n = 0;
        while (!init_done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_cycles", n, 64);

        io(1, 6'd5, 16'd50, 0, 6'd0, '0, 16'd0);
        io(0, 6'd0, 16'd0, 1, 6'd3, 512'hDEAD_BEEF, 16'd7);
        io(1, 6'd3, 16'd1, 0, 6'd0, '0, 16'd0);
        io(0, 6'd0, 16'd0, 1, 6'd9, 512'h11, 16'd8);
        io(1, 6'd9, 16'd2, 1, 6'd9, 512'h55, 16'd9);
        io(1, 6'd9, 16'd3, 0, 6'd0, '0, 16'd0);
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            io(1, 6'(i), 16'(i), 0, 6'd0, '0, 16'd0);
            chk("rd_almfull", rd_alm, 0);
        end
        repeat (8) @(posedge clk);
        #1;
        chk("err_after_burst", err, 0);

        for (int i = 0; i < 12; i++) begin
            v_rd_v = 1'b1;
            v_rd_m = 16'(i);
            if (i < 8)
                ovf_q.push_back('{mdata: 16'(i), data: '0, at: cyc + 12});
            @(posedge clk); #1;
        end
        v_rd_v = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("ovf_rsp_count", n_ovf, 8);
        chk("ovf_err", v_err, 3'b001);
        chk("ovf_q_left", ovf_q.size(), 0);

        io(1, 6'd1, 16'd31, 0, 6'd0, '0, 16'd0);
        io(1, 6'd2, 16'd32, 0, 6'd0, '0, 16'd0);
        io(1, 6'd3, 16'd33, 0, 6'd0, '0, 16'd0);
        reset = 1'b1;
        #1;
        chk("midrst_rd_valid", rd_rv, 0);
        rd_q.delete();
        wr_q.delete();
        clear_model();
        repeat (2) @(posedge clk);

        @(negedge clk);
        reset = 1'b0;
        rd_v = 1'b1;
        rd_a = 6'd4;
        rd_m = 16'd99;
        @(posedge clk); #1;
        rd_v = 1'b0;
        n = 1;
        while (!init_done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reinit_cycles", n, 64);
        chk("init_req_err", err, 3'b100);

        io(1, 6'd3, 16'd40, 0, 6'd0, '0, 16'd0);
        io(1, 6'd9, 16'd41, 0, 6'd0, '0, 16'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("rd_q_left", rd_q.size(), 0);
        chk("wr_q_left", wr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
